// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the keypad-to-divider entry sequencer.
package div_ctrl_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    function automatic int digits(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/hex_entry_reg.sv
// Operand register that accumulates hex digits typed MSB-first.
module hex_entry_reg
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load_first,
    input  logic               shift_en,
    input  logic [DIGIT_W-1:0] nibble,
    output logic [WIDTH-1:0]   value
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load_first) begin
            value <= WIDTH'(nibble);
        end else if (shift_en) begin
            value <= WIDTH'({value, nibble});
        end
    end

endmodule

// File: rtl/div_entry_ctrl.sv
// Keypad entry sequencer: collects A and B, starts the divider, shows Q/R.
// Optional build macro: DIV_ZERO_GUARD_EN (short-circuits B == 0 to SHOW with err_divzero).
module div_entry_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    input  logic               div_done,
    input  logic [WIDTH-1:0]   div_q,
    input  logic [WIDTH-1:0]   div_r,
    output logic               div_start,
    output logic [WIDTH-1:0]   A_bin,
    output logic [WIDTH-1:0]   B_bin,
    output logic               busy,
    output logic               result_valid,
    output logic [2:0]         state_o,
`ifdef DIV_ZERO_GUARD_EN
    output logic               err_divzero,
`endif
    output logic [2*WIDTH-1:0] disp_val
);

    localparam int N     = digits(WIDTH);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             a_load, a_shift, b_clr, b_shift;
    logic             cap_div, cap_zero;

`ifdef DIV_ZERO_GUARD_EN
    logic [WIDTH-1:0] b_shifted;
    logic             err_reg;
    assign b_shifted = WIDTH'({B_bin, key_code});
`endif

    hex_entry_reg #(.WIDTH(WIDTH)) u_a_reg (
        .clk        (clk),
        .rst        (rst),
        .clr        (1'b0),
        .load_first (a_load),
        .shift_en   (a_shift),
        .nibble     (key_code),
        .value      (A_bin)
    );

    hex_entry_reg #(.WIDTH(WIDTH)) u_b_reg (
        .clk        (clk),
        .rst        (rst),
        .clr        (b_clr),
        .load_first (1'b0),
        .shift_en   (b_shift),
        .nibble     (key_code),
        .value      (B_bin)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ENTER_A;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_load     = 1'b0;
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;
        cap_div    = 1'b0;
        cap_zero   = 1'b0;
        unique case (state)
            ENTER_A: if (key_valid) begin
                a_shift = 1'b1;
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    b_clr      = 1'b1;
                    state_next = ENTER_B;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ENTER_B: if (key_valid) begin
                b_shift = 1'b1;
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    state_next = START;
`ifdef DIV_ZERO_GUARD_EN
                    if (b_shifted == '0) begin
                        cap_zero   = 1'b1;
                        state_next = SHOW;
                    end
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            START: state_next = WAIT;
            // Keys arriving while the divider runs are dropped, even alongside div_done.
            WAIT: if (div_done) begin
                cap_div    = 1'b1;
                state_next = SHOW;
            end
            SHOW: if (key_valid) begin
                a_load = 1'b1;
                if (N == 1) begin
                    b_clr      = 1'b1;
                    cnt_next   = '0;
                    state_next = ENTER_B;
                end else begin
                    cnt_next   = CNT_W'(1);
                    state_next = ENTER_A;
                end
            end
            default: state_next = ENTER_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
            r_reg <= '0;
        end else if (cap_div) begin
            q_reg <= div_q;
            r_reg <= div_r;
        end else if (cap_zero) begin
            q_reg <= '1;
            r_reg <= A_bin;
        end
    end

`ifdef DIV_ZERO_GUARD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (cap_zero) begin
            err_reg <= 1'b1;
        end else if (state_next != SHOW) begin
            err_reg <= 1'b0;
        end
    end
    assign err_divzero = err_reg;
`endif

    assign div_start    = (state == START);
    assign busy         = (state == START) || (state == WAIT);
    assign result_valid = (state == SHOW);
    assign state_o      = state;

    always_comb begin
        disp_val = {A_bin, B_bin};
        if (state == ENTER_A) begin
            disp_val = {{WIDTH{1'b0}}, A_bin};
        end else if (state == SHOW) begin
            disp_val = {q_reg, r_reg};
        end
    end

endmodule

// File: tb/tb_div_entry_ctrl.sv
// Self-checking bench for div_entry_ctrl with a behavioural divider and arithmetic reference model.
module tb_div_entry_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               key_valid = 1'b0;
    logic [3:0]         key_code = '0;
    logic               div_done = 1'b0;
    logic [WIDTH-1:0]   div_q = '0;
    logic [WIDTH-1:0]   div_r = '0;
    logic               div_start;
    logic [WIDTH-1:0]   A_bin, B_bin;
    logic               busy, result_valid;
    logic [2:0]         state_o;
    logic [2*WIDTH-1:0] disp_val;
`ifdef DIV_ZERO_GUARD_EN
    logic               err_divzero;
`endif

    int total = 0;
    int bad   = 0;
    int starts = 0;
    logic [WIDTH-1:0] start_a = '0;
    logic [WIDTH-1:0] start_b = '0;

    div_entry_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .div_done     (div_done),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_start    (div_start),
        .A_bin        (A_bin),
        .B_bin        (B_bin),
        .busy         (busy),
        .result_valid (result_valid),
        .state_o      (state_o),
`ifdef DIV_ZERO_GUARD_EN
        .err_divzero  (err_divzero),
`endif
        .disp_val     (disp_val)
    );

    always #5 clk = ~clk;

    // Divider-side observer: counts start pulses and latches the operands it would see.
    always @(negedge clk) begin
        if (div_start) begin
            starts  <= starts + 1;
            start_a <= A_bin;
            start_b <= B_bin;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = N - 1; i >= 0; i--) press(a[4*i +: 4]);
        for (int i = N - 1; i >= 0; i--) press(b[4*i +: 4]);
    endtask

    // Reference: what the display should read once a division of a by b completes.
    function automatic logic [2*WIDTH-1:0] expect_disp(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        if (b == 0) return {{WIDTH{1'b1}}, a};
        return {WIDTH'(a / b), WIDTH'(a % b)};
    endfunction

    // Starts in the START cycle; answers after lat edges, optionally typing junk keys meanwhile.
    task automatic divide(input int lat, input int njunk, input logic [3:0] jkey,
                          input logic collide);
        logic [2*WIDTH-1:0] res;
        for (int i = 0; i < lat; i++) begin
            if (i < njunk) begin
                key_valid = 1'b1;
                key_code  = jkey;
            end
            tick();
            key_valid = 1'b0;
        end
        res      = expect_disp(start_a, start_b);
        div_done = 1'b1;
        div_q    = res[2*WIDTH-1:WIDTH];
        div_r    = res[WIDTH-1:0];
        if (collide) begin
            key_valid = 1'b1;
            key_code  = 4'hA;
        end
        tick();
        div_done  = 1'b0;
        key_valid = 1'b0;
    endtask

    initial begin
        int s0;
        logic [WIDTH-1:0] ra, rb;

        rst = 1'b0;
        repeat (2) tick();
        check("rst_state", state_o, 3'd0);
        check("rst_a", A_bin, 0);
        check("rst_b", B_bin, 0);
        check("rst_disp", disp_val, 0);
        check("rst_flags", {div_start, busy, result_valid}, 3'b000);
        rst = 1'b1;
        tick();

        // 0x45 / 0x07 = 9 rem 6
        s0 = starts;
        enter(8'h45, 8'h07);
        check("s1_a", A_bin, 8'h45);
        check("s1_b", B_bin, 8'h07);
        check("s1_start_pulse", div_start, 1'b1);
        check("s1_busy", busy, 1'b1);
        divide(20, 0, 4'h0, 1'b0);
        check("s1_nstart", starts - s0, 1);
        check("s1_disp", disp_val, 16'h0906);
        check("s1_valid", result_valid, 1'b1);
        check("s1_busy_after", busy, 1'b0);

        // 0x7E / 0x09 = 14 rem 0, first key leaves SHOW
        press(4'h7);
        check("s2_first_a", A_bin, 8'h07);
        check("s2_state", state_o, 3'd0);
        check("s2_valid", result_valid, 1'b0);
        press(4'hE);
        press(4'h0);
        press(4'h9);
        check("s2_a", A_bin, 8'h7E);
        check("s2_b", B_bin, 8'h09);
        divide(20, 0, 4'h0, 1'b0);
        check("s2_disp", disp_val, 16'h0E00);

        // Keys F,F typed during START/WAIT must be ignored
        s0 = starts;
        enter(8'h45, 8'h07);
        divide(20, 2, 4'hF, 1'b0);
        check("s3_a", A_bin, 8'h45);
        check("s3_b", B_bin, 8'h07);
        check("s3_nstart", starts - s0, 1);
        check("s3_disp", disp_val, 16'h0906);

        // Reset mid-WAIT, then a late done
        enter(8'h12, 8'h34);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("s4_state", state_o, 3'd0);
        check("s4_ab", {A_bin, B_bin}, 0);
        check("s4_disp", disp_val, 0);
        check("s4_flags", {div_start, busy, result_valid}, 3'b000);
        div_done = 1'b1;
        div_q    = 8'h55;
        div_r    = 8'h66;
        tick();
        div_done = 1'b0;
        check("s4_late_valid", result_valid, 1'b0);
        check("s4_late_state", state_o, 3'd0);
        check("s4_late_disp", disp_val, 0);

        // key_valid coinciding with div_done: 0x9C / 0x05 = 31 rem 1
        enter(8'h9C, 8'h05);
        divide(4, 0, 4'h0, 1'b1);
        check("s5_state", state_o, 3'd4);
        check("s5_a", A_bin, 8'h9C);
        check("s5_disp", disp_val, 16'h1F01);

        // Divisor zero
        s0 = starts;
`ifdef DIV_ZERO_GUARD_EN
        enter(8'h3C, 8'h00);
        check("s6_no_start", div_start, 1'b0);
        check("s6_state", state_o, 3'd4);
        check("s6_err", err_divzero, 1'b1);
        check("s6_disp", disp_val, 16'hFF3C);
        check("s6_nstart", starts - s0, 0);
`else
        enter(8'h3C, 8'h00);
        check("s6_start", div_start, 1'b1);
        check("s6_b", B_bin, 8'h00);
        divide(5, 0, 4'h0, 1'b0);
        check("s6_nstart", starts - s0, 1);
        check("s6_disp", disp_val, 16'hFF3C);
`endif
        press(4'h1);
        check("s6_leave_a", A_bin, 8'h01);
`ifdef DIV_ZERO_GUARD_EN
        check("s6_err_clr", err_divzero, 1'b0);
`endif
        press(4'h2);
        press(4'h0);
        press(4'h3);
        divide(7, 0, 4'h0, 1'b0);
        check("s6_follow_disp", disp_val, 16'h0600);

        // Randomised operands, latencies and junk keys
        for (int it = 0; it < 24; it++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            s0 = starts;
            enter(ra, rb);
`ifdef DIV_ZERO_GUARD_EN
            if (rb == 0) begin
                check("rnd_nstart_zero", starts - s0, 0);
                check("rnd_err", err_divzero, 1'b1);
            end else begin
                check("rnd_ab", {A_bin, B_bin}, {ra, rb});
                divide($urandom_range(1, 30), $urandom_range(0, 3), 4'($urandom), 1'b0);
                check("rnd_nstart", starts - s0, 1);
            end
`else
            check("rnd_ab", {A_bin, B_bin}, {ra, rb});
            divide($urandom_range(1, 30), $urandom_range(0, 3), 4'($urandom), 1'b0);
            check("rnd_nstart", starts - s0, 1);
`endif
            check("rnd_valid", result_valid, 1'b1);
            check("rnd_disp", disp_val, expect_disp(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_entry_ctrl.md
Name: div_entry_ctrl

Overview:
- Sequencer between the debounced 4x4 keypad decoder and the shared restoring divider in top_divisor.
- Collects hex digits for dividend A, then divisor B, and pulses div_start.
- Waits for div_done, captures quotient and remainder, and presents them on the 7-segment display bus until the next key press starts a new entry.

Parameters:
- WIDTH, 8, operand width in bits. Must be a multiple of 4. Digits per operand N = WIDTH/4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- key_valid  in  1  one-cycle pulse, debounced key press
- key_code  in  4  hex value of the pressed key (0x0-0xF), valid with key_valid
- div_done  in  1  one-cycle pulse from the divider, result valid
- div_q  in  WIDTH  quotient (Cociente) from the divider
- div_r  in  WIDTH  remainder (Residuo) from the divider
- div_start  out  1  one-cycle start pulse to the divider
- A_bin  out  WIDTH  dividend to the divider
- B_bin  out  WIDTH  divisor to the divider
- busy  out  1  high in START and WAIT
- result_valid  out  1  high in SHOW
- state_o  out  3  current state encoding, for debug
- disp_val  out  2*WIDTH  value for the display driver

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to ENTER_A.
  - A_bin, B_bin, Q/R capture registers, disp_val and the digit counter all go to 0.
  - div_start, busy and result_valid go to 0.
  - Reset wins over every other event, including mid-WAIT; a late div_done after reset is ignored.
- ENTER_A:
  - Each key_valid: A_bin <= {A_bin[WIDTH-5:0], key_code}; cnt++.
  - On the Nth digit: cnt <= 0, B_bin <= 0, go to ENTER_B.
  - disp_val = {WIDTH'0, A_bin}.
- ENTER_B:
  - Same shifting into B_bin.
  - On the Nth digit, go to START.
  - disp_val = {A_bin, B_bin}.
- START:
  - div_start = 1 for exactly this one cycle; next state is WAIT.
  - A_bin and B_bin are held stable from START until SHOW is entered.
- WAIT:
  - Waits for div_done, sampled from the cycle after START.
  - On div_done: capture Q <= div_q and R <= div_r; go to SHOW.
  - No timeout.
- SHOW:
  - result_valid = 1; disp_val = {Q, R}.
  - A key_valid loads A_bin <= {WIDTH-4 zeros, key_code}, sets cnt = 1 and goes to ENTER_A, with N > 1.
  - If N == 1, it instead goes straight to ENTER_B.
- Ignored events:
  - key_valid is ignored in START and WAIT (no queueing).
  - div_done is ignored outside WAIT.
  - If key_valid and div_done coincide in WAIT, the result is captured and the key is dropped.
- div_start is never asserted in any state other than START.
- All outputs are registered except disp_val and the status outputs, which are a combinational function of state and registers.

Optional Feature:
- Macro: DIV_ZERO_GUARD_EN
- Defined:
  - In ENTER_B, when the last digit makes B == 0, the block goes directly to SHOW.
  - div_start is not pulsed.
  - Q is forced to all-ones and R to A_bin.
  - Extra output err_divzero (1 bit) is high while in that SHOW; it is cleared on leaving SHOW and on reset.
- Undefined:
  - B == 0 is passed to the divider like any other value.
  - The err_divzero port does not exist.

Decomposition:
- Package div_ctrl_pkg contains:
  - typedef enum logic [2:0] state_t {ENTER_A, ENTER_B, START, WAIT, SHOW}
  - localparam DIGIT_W = 4
  - function digits(width) returning width/4
- One sub-module, hex_entry_reg (parameter WIDTH):
  - Inputs: clr, load_first, shift_en, nibble.
  - Output: value.
  - Instantiated twice, once for A and once for B.
- FSM, counter and capture logic stay in div_entry_ctrl.

Test Plan:
- Keys 4,5,0,7, with a behavioural divider returning after 20 cycles:
  - A_bin = 0x45, B_bin = 0x07.
  - Exactly one div_start pulse.
  - disp_val = 0x0906; result_valid = 1.
- Then keys 7,E,0,9:
  - The first key leaves SHOW with A_bin = 0x07 after that key.
  - Final A_bin = 0x7E, B_bin = 0x09.
  - disp_val = 0x0E00.
- Keys pressed during WAIT (F,F):
  - No change to A_bin or B_bin.
  - No second div_start.
  - Result is still 0x45/0x07 → 0x0906.
- rst low for one cycle mid-WAIT, then div_done pulses:
  - State is ENTER_A; all outputs are 0.
  - The late done is ignored; result_valid stays 0.
- key_valid and div_done in the same cycle in WAIT:
  - Q/R are captured; SHOW is entered.
  - A_bin is unchanged by the key.
- With DIV_ZERO_GUARD_EN, keys 3,C,0,0:
  - No div_start.
  - err_divzero = 1; disp_val = 0xFF3C.
- Without DIV_ZERO_GUARD_EN, keys 3,C,0,0:
  - div_start pulses with B_bin = 0x00.
